// File: rtl/inst_fetch.sv
// Instruction fetch unit: assembles 16-bit instructions from two consecutive
// bytes of a synchronous-read byte memory and presents them with a valid/ready handshake.
module inst_fetch #(
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    redirect_valid,
    input  logic [ADDR_WIDTH-1:0]   redirect_addr,
    output logic                    mem_ce,
    output logic                    mem_rw,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [2*DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]   instr_pc,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic                    busy
);

    localparam logic [ADDR_WIDTH-1:0] EVEN_MASK  = ~ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PC_RESET   = RESET_PC & EVEN_MASK;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_CAP,
        S_HOLD
    } state_e;

    state_e                  state_q,    state_d;
    logic [ADDR_WIDTH-1:0]   pc_q,       pc_d;
    logic [DATA_WIDTH-1:0]   hi_byte_q,  hi_byte_d;
    logic [2*DATA_WIDTH-1:0] instr_q,    instr_d;
    logic [ADDR_WIDTH-1:0]   instr_pc_q, instr_pc_d;
    logic                    valid_q,    valid_d;
    logic                    handshake;

    assign handshake = valid_q && instr_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        hi_byte_d  = hi_byte_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;

        unique case (state_q)
            S_IDLE: begin
                if (en) state_d = S_HI;
            end
            S_HI: begin
                state_d = S_LO;
            end
            S_LO: begin
                hi_byte_d = mem_rdata;
                state_d   = S_CAP;
            end
            S_CAP: begin
                instr_d    = {hi_byte_q, mem_rdata};
                instr_pc_d = pc_q;
                valid_d    = 1'b1;
                pc_d       = pc_q + ADDR_WIDTH'(2);
                state_d    = S_HOLD;
            end
            S_HOLD: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    state_d = en ? S_HI : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A redirect wins over everything in flight, including a same-cycle handshake.
        if (redirect_valid) begin
            pc_d       = redirect_addr & EVEN_MASK;
            hi_byte_d  = hi_byte_q;
            instr_d    = instr_q;
            instr_pc_d = instr_pc_q;
            valid_d    = 1'b0;
            state_d    = en ? S_HI : S_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            pc_q       <= PC_RESET;
            hi_byte_q  <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hi_byte_q  <= hi_byte_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

    // The low byte always sits at pc+1; pc is even so setting bit 0 is enough.
    always_comb begin
        mem_addr = pc_q;
        if (state_q == S_LO) mem_addr = pc_q | ADDR_WIDTH'(1);
    end

    assign mem_ce      = !clr && ((state_q == S_HI) || (state_q == S_LO));
    assign mem_rw      = 1'b1;
    assign mem_wdata   = '0;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign busy        = (state_q != S_IDLE);

endmodule
